pool2_seq_ctrl: RTL

- Sequencer for the 2x2 max-pool engine (pool2, 3x16-bit lanes, 11x11 frame).
- On start, streams GROUPS channel-group frames from the feature-map RAM into the pool engine back-to-back, with 1-cycle RAM latency compensation.
- Writes every valid pooled pixel to the output RAM at sequential addresses, then pulses done.
- Sits between the conv2 output buffer and the next layer's input buffer.

---
 rtl/pool_pkg.sv | 19 +
 rtl/fm_scan_cnt.sv | 67 ++++++
 rtl/pool2_seq_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared constants and sequencer state type for the pool stages
// Purpose: frame geometry and lane layout of the pool2 engine, plus the
//          sequencer state enum used by pool sequencers.
// Ports:   none (package)
package pool_pkg;

    localparam int P2_IMG_W  = 11;
    localparam int P2_IMG_H  = 11;
    localparam int P2_LANES  = 3;
    localparam int P2_LANE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } p2_state_t;

endpackage

// File: rtl/fm_scan_cnt.sv
// rtl/fm_scan_cnt.sv - x/y/group raster counter with linear read address
// Purpose: steps a raster over G frames of W x H pixels, one pixel per enabled cycle.
// Ports:   clk, rst_n (async, active-high), clr (sync clear), en (advance one pixel),
//          addr (linear address of the current pixel), frame_end (current pixel is the
//          last of its frame), last (current pixel is the last of the last frame).
module fm_scan_cnt #(
    parameter int W  = 11,
    parameter int H  = 11,
    parameter int G  = 4,
    parameter int AW = $clog2(G * W * H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          frame_end,
    output logic          last
);

    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam int YW = (H > 1) ? $clog2(H) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [GW-1:0] g;
    logic          x_end;
    logic          y_end;
    logic          g_end;

    assign x_end     = (x == XW'(W - 1));
    assign y_end     = (y == YW'(H - 1));
    assign g_end     = (g == GW'(G - 1));
    assign frame_end = x_end & y_end;
    assign last      = frame_end & g_end;

    // The raster is contiguous in memory, so group*W*H + y*W + x is simply a
    // running count; it is kept alongside x/y/g instead of being multiplied out.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            x    <= '0;
            y    <= '0;
            g    <= '0;
            addr <= '0;
        end else if (clr) begin
            x    <= '0;
            y    <= '0;
            g    <= '0;
            addr <= '0;
        end else if (en) begin
            addr <= addr + 1'b1;
            if (x_end) begin
                x <= '0;
                if (y_end) begin
                    y <= '0;
                    g <= g_end ? '0 : g + 1'b1;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool2_seq_ctrl.sv
// rtl/pool2_seq_ctrl.sv - sequencer feeding feature-map frames through the pool2 engine
// Purpose: on start, reads GROUPS frames from the feature RAM into the pool engine,
//          writes every valid pooled pixel to the output RAM sequentially, pulses done,
//          and flags any group whose write count is not (W/2)*(H/2).
// Ports:   clk, rst_n (async, active-high), start, pause;
//          fm_rd_en/fm_rd_addr/fm_rd_data (feature RAM, 1-cycle read latency);
//          pool_in_data/pool_in_valid, pool_out_data/pool_out_valid (pool engine);
//          out_wr_en/out_wr_addr/out_wr_data (output RAM); busy, done, err.
module pool2_seq_ctrl
    import pool_pkg::*;
#(
    parameter int IMG_W  = P2_IMG_W,
    parameter int IMG_H  = P2_IMG_H,
    parameter int GROUPS = 4,
    parameter int DW     = P2_LANES * P2_LANE_W,
    parameter int RD_AW  = $clog2(GROUPS * IMG_W * IMG_H),
    parameter int WR_AW  = $clog2(GROUPS * (IMG_W / 2) * (IMG_H / 2))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    output logic             fm_rd_en,
    output logic [RD_AW-1:0] fm_rd_addr,
    input  logic [DW-1:0]    fm_rd_data,
    output logic [DW-1:0]    pool_in_data,
    output logic             pool_in_valid,
    input  logic [DW-1:0]    pool_out_data,
    input  logic             pool_out_valid,
    output logic             out_wr_en,
    output logic [WR_AW-1:0] out_wr_addr,
    output logic [DW-1:0]    out_wr_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int OUT_PER_GROUP = (IMG_W / 2) * (IMG_H / 2);
    // Sized for the worst case of one write per input pixel so a runaway
    // engine cannot wrap the counter back onto the expected value.
    localparam int CW = $clog2(IMG_W * IMG_H + 1);

    p2_state_t      state;
    p2_state_t      state_nx;
    logic           start_acc;
    logic           scan_frame_end;
    logic           scan_last;
    logic           grp_end_d;
    logic [CW-1:0]  wr_cnt;
    logic [CW-1:0]  cnt_incl;

    assign start_acc = (state == IDLE) & start;
    assign fm_rd_en  = (state == RUN) & ~pause;

    fm_scan_cnt #(
        .W  (IMG_W),
        .H  (IMG_H),
        .G  (GROUPS),
        .AW (RD_AW)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_acc),
        .en        (fm_rd_en),
        .addr      (fm_rd_addr),
        .frame_end (scan_frame_end),
        .last      (scan_last)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (fm_rd_en && scan_last) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN) | (state == DRAIN);
    assign done = (state == DONE);

    // RAM data arrives one cycle after the read, so valid and the group-end
    // marker are delayed to line up with it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pool_in_valid <= 1'b0;
            grp_end_d     <= 1'b0;
        end else begin
            pool_in_valid <= fm_rd_en;
            grp_end_d     <= fm_rd_en & scan_frame_end;
        end
    end

    assign pool_in_data = fm_rd_data;
    assign out_wr_data  = pool_out_data;

    // The engine's output valid follows its own raster position even on
    // cycles without input, so it is only trusted alongside an input pixel.
    assign out_wr_en = pool_out_valid & pool_in_valid & busy;
    assign cnt_incl  = wr_cnt + CW'(out_wr_en);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_wr_addr <= '0;
            wr_cnt      <= '0;
            err         <= 1'b0;
        end else if (start_acc) begin
            out_wr_addr <= '0;
            wr_cnt      <= '0;
            err         <= 1'b0;
        end else begin
            if (out_wr_en) begin
                out_wr_addr <= out_wr_addr + 1'b1;
            end
            // The group's last pixel may itself produce a write, hence cnt_incl.
            if (grp_end_d) begin
                if (cnt_incl != CW'(OUT_PER_GROUP)) begin
                    err <= 1'b1;
                end
                wr_cnt <= '0;
            end else begin
                wr_cnt <= cnt_incl;
            end
        end
    end

endmodule
